ula_seq: RTL and testbench

Sequencing controller for the 8-bit ripple ALU (`ula`). It accepts one operation request at a time over a valid/ready handshake and decodes the opcode into the ALU control lines (`Ainvert`, `Bnegate`, `operation`). It captures result and flags and returns them over a second valid/ready handshake. It also implements an 8-bit multiply (low byte) by iterating the ALU's add path over 8 cycles. It sits between the instruction/issue logic and the combinational ALU, which it drives through external ports.

---
 rtl/ula_seq.sv | 157 +++++++++++++++
 tb/tb_ula_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// Sequencing controller for the 8-bit ripple ALU: one request at a time over
// valid/ready, opcode decode onto the ALU control lines, and shift-add multiply.
module ula_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ainvert,
  output logic             alu_bnegate,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and ready here depends on state only.
  logic [1:0]       state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] mcand;   // operand a; shifted left during MUL
  logic [WIDTH-1:0] mplier;  // operand b; shifted right during MUL
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             ovf_q;
  logic             err_q;

  assign in_ready     = (state == S_IDLE);
  assign out_valid    = (state == S_DONE);
  assign out_result   = res_q;
  assign out_zero     = zero_q;
  assign out_overflow = ovf_q;
  assign out_err      = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q   <= in_opcode;
            mcand  <= in_a;
            mplier <= in_b;
            acc    <= '0;
            count  <= '0;
            state  <= (in_opcode == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_q == OP_ILL) begin
            res_q  <= '0;
            zero_q <= 1'b1;
            ovf_q  <= 1'b0;
            err_q  <= 1'b1;
          end else begin
            res_q  <= alu_result;
            zero_q <= alu_zero;
            ovf_q  <= alu_overflow;
            err_q  <= 1'b0;
          end
          state <= S_DONE;
        end
        S_MUL: begin
          acc    <= alu_result;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          // The ALU output this cycle already is the final accumulator value.
          if (count == LAST_ITER) begin
            res_q  <= alu_result;
            zero_q <= (alu_result == '0);
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_ainvert = 1'b0;
    alu_bnegate = 1'b0;
    alu_op      = 2'b00;
    case (state)
      S_EXEC: begin
        if (op_q != OP_ILL) begin
          alu_a = mcand;
          alu_b = mplier;
        end
        case (op_q)
          OP_AND: alu_op = 2'b00;
          OP_OR:  alu_op = 2'b01;
          OP_ADD: alu_op = 2'b10;
          OP_SUB: begin alu_bnegate = 1'b1; alu_op = 2'b10; end
          OP_SLT: begin alu_bnegate = 1'b1; alu_op = 2'b11; end
          OP_NOR: begin alu_ainvert = 1'b1; alu_bnegate = 1'b1; alu_op = 2'b00; end
          default: alu_op = 2'b00;
        endcase
      end
      S_MUL: begin
        alu_a  = acc;
        alu_b  = mplier[0] ? mcand : '0;
        alu_op = 2'b10;
      end
      default: alu_op = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq: a behavioural stand-in for the ripple ALU, directed cases
// and randomized operations checked against an arithmetic reference model.
module tb_ula_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_opcode;
  logic [7:0] in_a, in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_zero, out_overflow, out_err;
  logic [7:0] alu_a, alu_b;
  logic       alu_ainvert, alu_bnegate;
  logic [1:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_zero, alu_overflow;

  int tests = 0;
  int fails = 0;
  logic [3:0] dec_tab [0:5];

  ula_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_overflow(out_overflow), .out_err(out_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ainvert(alu_ainvert),
    .alu_bnegate(alu_bnegate), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow)
  );

  always #5 clk = ~clk;

  // Ripple ALU stand-in: invert/negate inputs, carry-in = Bnegate, SLT from adder MSB.
  logic [7:0] aa, bb;
  logic [8:0] sum;
  always_comb begin
    aa  = alu_ainvert ? ~alu_a : alu_a;
    bb  = alu_bnegate ? ~alu_b : alu_b;
    sum = {1'b0, aa} + {1'b0, bb} + {8'b0, alu_bnegate};
    case (alu_op)
      2'b00:   alu_result = aa & bb;
      2'b01:   alu_result = aa | bb;
      2'b10:   alu_result = sum[7:0];
      default: alu_result = {7'b0, sum[7]};
    endcase
    alu_overflow = alu_op[1] && (aa[7] == bb[7]) && (sum[7] != aa[7]);
    alu_zero     = (alu_result == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] r, output logic z, output logic o, output logic e);
    int prod;
    logic [7:0] d;
    o = 1'b0;
    e = 1'b0;
    d = a - b;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin r = a + b; o = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd3: begin r = d;     o = (a[7] != b[7]) && (d[7] != a[7]); end
      3'd4: begin r = {7'b0, d[7]}; o = (a[7] != b[7]) && (d[7] != a[7]); end
      3'd5: r = ~(a | b);
      3'd6: begin prod = int'(a) * int'(b); r = prod[7:0]; end
      default: begin r = 8'h00; e = 1'b1; end
    endcase
    z = (r == 8'h00);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_alu_ab"}, {alu_a, alu_b}, 32'h0);
    check({tag, "_alu_ctl"}, {alu_ainvert, alu_bnegate, alu_op}, 32'h0);
  endtask

  // One complete transaction; hold = number of DONE cycles with out_ready low.
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [7:0] er;
    logic ez, eo, ee;
    int cyc;
    ref_model(op, a, b, er, ez, eo, ee);
    cyc = 0;
    while (!in_ready && cyc < 20) begin @(negedge clk); cyc++; end
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom); in_opcode = 3'($urandom);
    check("in_ready_busy", in_ready, 0);
    check("out_valid_busy", out_valid, 0);
    if (op == 3'd6) begin
      check("mul_ctl", {alu_ainvert, alu_bnegate, alu_op}, 32'b0010);
      check("mul_acc0", alu_a, 0);
    end else if (op == 3'd7) begin
      check_quiet("ill");
    end else begin
      check("exec_ctl", {alu_ainvert, alu_bnegate, alu_op}, {28'b0, dec_tab[op]});
      check("exec_ab", {alu_a, alu_b}, {16'b0, a, b});
    end
    cyc = 1;
    while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
    check("latency", cyc, (op == 3'd6) ? 9 : 2);
    check("result", out_result, er);
    check("flags", {out_zero, out_overflow, out_err}, {ez, eo, ee});
    check_quiet("done");
    for (int i = 0; i < hold; i++) begin
      check("hold_result", out_result, er);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    if (hold > 0) check("hold_end_result", out_result, er);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_outs"}, {out_result, out_zero, out_overflow, out_err}, 0);
    check_quiet(tag);
  endtask

  initial begin
    dec_tab[0] = 4'b0000; dec_tab[1] = 4'b0001; dec_tab[2] = 4'b0010;
    dec_tab[3] = 4'b0110; dec_tab[4] = 4'b0111; dec_tab[5] = 4'b1100;
    rst = 1'b1; in_valid = 1'b0; in_opcode = 3'd0; in_a = 8'h00; in_b = 8'h00; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    do_op(3'd2, 8'h7F, 8'h01, 0);
    do_op(3'd3, 8'h05, 8'h05, 0);
    do_op(3'd4, 8'h03, 8'h05, 0);
    do_op(3'd5, 8'h0F, 8'hF0, 0);
    do_op(3'd6, 8'h0D, 8'h0B, 0);
    do_op(3'd6, 8'h10, 8'h10, 0);
    do_op(3'd0, 8'hF0, 8'h3C, 5);
    do_op(3'd7, 8'hAA, 8'h55, 0);
    do_op(3'd1, 8'h12, 8'h40, 0);

    // Reset in the middle of a multiply: nothing may come out of it.
    in_valid = 1'b1; in_opcode = 3'd6; in_a = 8'h0D; in_b = 8'h0B; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("midmul");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midmul_no_valid", out_valid, 0);
    end
    out_ready = 1'b0;
    do_op(3'd2, 8'h02, 8'h03, 0);

    for (int n = 0; n < 40; n++) begin
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
